// File: rtl/yc_to_ycbcr_pkg.sv
// Shared constants and types for the YC 4:2:2 to YCbCr 4:4:4 upsampler.
package yc_to_ycbcr_pkg;

    localparam int unsigned C_DATA_WIDTH_DEFAULT = 10;
    localparam int unsigned LATENCY              = 4;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

    // Mid-scale chroma code used when no Cr sample exists in a run.
    function automatic int unsigned mid_code(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    function automatic phase_t next_phase(input logic de, input phase_t ph);
        if (!de) begin
            return PH_EVEN;
        end
        return (ph == PH_EVEN) ? PH_ODD : PH_EVEN;
    endfunction

endpackage

// File: rtl/yc_to_ycbcr_chroma_avg.sv
// Registered rounding average of two chroma samples, widened by one bit so it never wraps.
module chroma_avg
    import yc_to_ycbcr_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = C_DATA_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [C_DATA_WIDTH-1:0] a,
    input  logic [C_DATA_WIDTH-1:0] b,
    output logic [C_DATA_WIDTH-1:0] avg
);

    localparam logic [C_DATA_WIDTH:0] ROUND = 1;

    logic [C_DATA_WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + ROUND;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avg <= '0;
        end else begin
            avg <= sum[C_DATA_WIDTH:1];
        end
    end

endmodule

// File: rtl/yc_to_ycbcr.sv
// 4:2:2 multiplexed-chroma to 4:4:4 upsampler with fixed 4-clock latency.
module yc_to_ycbcr
    import yc_to_ycbcr_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = C_DATA_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    VS_in,
    input  logic                    HS_in,
    input  logic                    DE_in,
    input  logic [C_DATA_WIDTH-1:0] Y_in,
    input  logic [C_DATA_WIDTH-1:0] C_in,
    output logic                    VS_out,
    output logic                    HS_out,
    output logic                    DE_out,
    output logic [C_DATA_WIDTH-1:0] Y_out,
    output logic [C_DATA_WIDTH-1:0] Cb_out,
    output logic [C_DATA_WIDTH-1:0] Cr_out
);

    localparam logic [C_DATA_WIDTH-1:0] MID_CODE = C_DATA_WIDTH'(mid_code(C_DATA_WIDTH));

    typedef struct packed {
        logic                    vs;
        logic                    hs;
        logic                    de;
        logic [C_DATA_WIDTH-1:0] y;
        logic [C_DATA_WIDTH-1:0] c;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{vs: 1'b1, hs: 1'b1, de: 1'b0, y: '0, c: '0};

    // pipe[0] is the newest pixel; the chroma window is centred on pipe[1].
    stage_t pipe [LATENCY-1];
    phase_t phase;
    phase_t phase_d;
    phase_t ph_s1;
    phase_t ph_s2;

    logic [C_DATA_WIDTH-1:0] cb_a;
    logic [C_DATA_WIDTH-1:0] cb_b;
    logic [C_DATA_WIDTH-1:0] cr_a;
    logic [C_DATA_WIDTH-1:0] cr_b;
    logic [C_DATA_WIDTH-1:0] cb_avg;
    logic [C_DATA_WIDTH-1:0] cr_avg;

    always_comb begin
        phase_d = next_phase(DE_in, phase);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase <= PH_EVEN;
            ph_s1 <= PH_EVEN;
            ph_s2 <= PH_EVEN;
            for (int unsigned i = 0; i < LATENCY - 1; i++) begin
                pipe[i] <= STAGE_IDLE;
            end
        end else begin
            phase   <= phase_d;
            ph_s1   <= phase;
            ph_s2   <= ph_s1;
            pipe[0] <= '{vs: VS_in, hs: HS_in, de: DE_in, y: Y_in, c: C_in};
            for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Samples that are absent from the run are replaced by the centre value,
    // so the averager degenerates to a pass-through and needs no output mux.
    always_comb begin
        cb_a = pipe[1].c;
        cb_b = pipe[1].c;
        cr_a = MID_CODE;
        cr_b = MID_CODE;
        if (ph_s2 == PH_EVEN) begin
            if (pipe[0].de) begin
                cr_a = pipe[0].c;
                cr_b = pipe[0].c;
            end else if (pipe[2].de) begin
                cr_a = pipe[2].c;
                cr_b = pipe[2].c;
            end
        end else begin
            cb_a = pipe[2].c;
            cb_b = pipe[0].de ? pipe[0].c : pipe[2].c;
            cr_a = pipe[1].c;
            cr_b = (pipe[0].de && DE_in) ? C_in : pipe[1].c;
        end
    end

    chroma_avg #(
        .C_DATA_WIDTH(C_DATA_WIDTH)
    ) u_cb_avg (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (cb_a),
        .b       (cb_b),
        .avg     (cb_avg)
    );

    chroma_avg #(
        .C_DATA_WIDTH(C_DATA_WIDTH)
    ) u_cr_avg (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (cr_a),
        .b       (cr_b),
        .avg     (cr_avg)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            VS_out <= 1'b1;
            HS_out <= 1'b1;
            DE_out <= 1'b0;
            Y_out  <= '0;
            Cb_out <= '0;
            Cr_out <= '0;
        end else begin
            VS_out <= pipe[2].vs;
            HS_out <= pipe[2].hs;
            DE_out <= pipe[2].de;
            Y_out  <= pipe[2].de ? pipe[2].y : '0;
            Cb_out <= pipe[2].de ? cb_avg : '0;
            Cr_out <= pipe[2].de ? cr_avg : '0;
        end
    end

endmodule

// File: tb/tb_yc_to_ycbcr.sv
// Bench for yc_to_ycbcr: directed corner runs plus random traffic against a run-level model.
module tb_yc_to_ycbcr;

    localparam int W   = 10;
    localparam int MID = 1 << (W - 1);
    localparam int N   = 4096;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         VS_in, HS_in, DE_in;
    logic [W-1:0] Y_in, C_in;
    logic         VS_out, HS_out, DE_out;
    logic [W-1:0] Y_out, Cb_out, Cr_out;

    yc_to_ycbcr #(
        .C_DATA_WIDTH(W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .VS_in   (VS_in),
        .HS_in   (HS_in),
        .DE_in   (DE_in),
        .Y_in    (Y_in),
        .C_in    (C_in),
        .VS_out  (VS_out),
        .HS_out  (HS_out),
        .DE_out  (DE_out),
        .Y_out   (Y_out),
        .Cb_out  (Cb_out),
        .Cr_out  (Cr_out)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int e      = 0;

    // Applied stimulus and observed outputs, indexed by the clock edge number.
    logic rst_a [N];
    logic vs_a  [N];
    logic hs_a  [N];
    logic de_a  [N];
    int   y_a   [N];
    int   c_a   [N];
    logic ovs   [N];
    logic ohs   [N];
    logic ode   [N];
    int   oy    [N];
    int   ocb   [N];
    int   ocr   [N];

    int seq [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output after edge n belongs to the pixel sampled at edge n-3; chroma is
    // derived from the Cb/Cr sample lists of the run that pixel belongs to.
    function automatic void model(input int n, output int vs, output int hs, output int de,
                                  output int y, output int cb, output int cr);
        int m, s, last, k, b;
        vs = 1; hs = 1; de = 0; y = 0; cb = 0; cr = 0;
        for (int j = n - 3; j <= n; j++) begin
            if (j < 0 || rst_a[j]) return;
        end
        m  = n - 3;
        vs = int'(vs_a[m]);
        hs = int'(hs_a[m]);
        de = int'(de_a[m]);
        if (!de_a[m]) return;
        y = y_a[m];
        s = m;
        while (s > 0 && de_a[s-1] && !rst_a[s-1]) s--;
        last = m;
        while (last < n - 1 && de_a[last+1] && !rst_a[last+1]) last++;
        k = (m - s) / 2;
        b = s + 2 * k;
        if (((m - s) % 2) == 0) begin
            cb = c_a[b];
            if (b + 1 <= last)  cr = c_a[b+1];
            else if (k > 0)     cr = c_a[b-1];
            else                cr = MID;
        end else begin
            cb = (b + 2 <= last) ? (c_a[b] + c_a[b+2] + 1) / 2 : c_a[b];
            cr = (b + 3 <= last) ? (c_a[b+1] + c_a[b+3] + 1) / 2 : c_a[b+1];
        end
    endfunction

    task automatic step(input logic rn, input logic vs, input logic hs, input logic de,
                        input int y, input int c);
        int evs, ehs, ede, ey, ecb, ecr;
        if (e >= N) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", e, N);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
            $fatal(1, "cycle budget exhausted");
        end
        reset_n  = rn;
        VS_in    = vs;
        HS_in    = hs;
        DE_in    = de;
        Y_in     = y[W-1:0];
        C_in     = c[W-1:0];
        rst_a[e] = !rn;
        vs_a[e]  = vs;
        hs_a[e]  = hs;
        de_a[e]  = de;
        y_a[e]   = y & ((1 << W) - 1);
        c_a[e]   = c & ((1 << W) - 1);
        @(posedge clk);
        #1;
        ovs[e] = VS_out;
        ohs[e] = HS_out;
        ode[e] = DE_out;
        oy[e]  = int'(Y_out);
        ocb[e] = int'(Cb_out);
        ocr[e] = int'(Cr_out);
        model(e, evs, ehs, ede, ey, ecb, ecr);
        check_val($sformatf("vs@%0d", e), VS_out, evs);
        check_val($sformatf("hs@%0d", e), HS_out, ehs);
        check_val($sformatf("de@%0d", e), DE_out, ede);
        check_val($sformatf("y@%0d", e),  Y_out,  ey);
        check_val($sformatf("cb@%0d", e), Cb_out, ecb);
        check_val($sformatf("cr@%0d", e), Cr_out, ecr);
        e++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic run_seq(output int e0);
        e0 = e;
        for (int i = 0; i < seq.size(); i++) step(1'b1, 1'b0, 1'b0, 1'b1, 16 + i, seq[i]);
    endtask

    task automatic check_pix(input string tag, input int e0, input int i, input int cb, input int cr);
        check_val($sformatf("%s_de%0d", tag, i), ode[e0+3+i], 1);
        check_val($sformatf("%s_cb%0d", tag, i), ocb[e0+3+i], cb);
        check_val($sformatf("%s_cr%0d", tag, i), ocr[e0+3+i], cr);
    endtask

    initial begin
        int e0, e1, er;
        int cv;

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("rst_vs", ovs[e-1], 1);
        check_val("rst_hs", ohs[e-1], 1);
        check_val("rst_de", ode[e-1], 0);
        check_val("rst_cr", ocr[e-1], 0);
        idle(2);

        seq = '{100, 200, 300, 400};
        run_seq(e0);
        idle(4);
        check_val("lat_pre", ode[e0+2], 0);
        check_val("lat_y0", oy[e0+3], 16);
        check_pix("run4", e0, 0, 100, 200);
        check_pix("run4", e0, 1, 200, 300);
        check_pix("run4", e0, 2, 300, 400);
        check_pix("run4", e0, 3, 300, 400);
        check_val("run4_end", ode[e0+7], 0);

        seq = '{1, 1023, 2, 1023};
        run_seq(e0);
        idle(4);
        check_pix("round", e0, 1, 2, 1023);
        seq = '{1023, 1023, 1023, 1023};
        run_seq(e0);
        idle(4);
        check_pix("nowrap", e0, 1, 1023, 1023);

        seq = '{10, 20, 30};
        run_seq(e0);
        idle(4);
        check_pix("run3", e0, 0, 10, 20);
        check_pix("run3", e0, 1, 20, 20);
        check_pix("run3", e0, 2, 30, 20);

        seq = '{77};
        run_seq(e0);
        idle(1);
        seq = '{5, 6, 7, 8};
        run_seq(e1);
        idle(4);
        check_pix("run1", e0, 0, 77, MID);
        check_val("gap_de", ode[e0+4], 0);
        check_pix("regap", e1, 0, 5, 6);
        check_pix("regap", e1, 1, 6, 7);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, i, 100 + i);
        er = e;
        step(1'b0, 1'b0, 1'b0, 1'b1, 3, 103);
        check_val("mid_rst_vs", ovs[er], 1);
        check_val("mid_rst_hs", ohs[er], 1);
        check_val("mid_rst_de", ode[er], 0);
        check_val("mid_rst_y",  oy[er],  0);
        check_val("mid_rst_cb", ocb[er], 0);
        check_val("mid_rst_cr", ocr[er], 0);
        idle(3);
        seq = '{40, 50, 60, 70};
        run_seq(e0);
        idle(4);
        check_pix("post_rst", e0, 0, 40, 50);
        check_pix("post_rst", e0, 1, 50, 60);
        check_pix("post_rst", e0, 3, 60, 70);

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 5))
                0:       cv = 0;
                1:       cv = (1 << W) - 1;
                default: cv = int'($urandom_range(0, (1 << W) - 1));
            endcase
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) != 0,
                 int'($urandom_range(0, (1 << W) - 1)),
                 cv);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
